// File: rtl/gb_ppu_common_pkg.sv
// Shared PPU definitions.
// OAM DMA state encoding, sizes and echo-RAM remap helper.
package gb_ppu_common_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } dma_state_t;

    localparam int unsigned OAM_DMA_LEN       = 160;
    localparam logic [15:0] OAM_BASE_ADDR     = 16'hFE00;
    localparam logic [7:0]  ECHO_REMAP_THRESH = 8'hE0;

    // Pages 0xE0-0xFF alias echo RAM at 0xC0-0xDF.
    function automatic logic [7:0] dma_src_eff(input logic [7:0] hi);
        return (hi >= ECHO_REMAP_THRESH) ? (hi - 8'h20) : hi;
    endfunction

endpackage

// File: rtl/gb_oam_dma.sv
// OAM DMA controller: copies one 160-byte source page into OAM,
// one byte per M-cycle, with a one-cycle read-to-write pipeline.
module gb_oam_dma
    import gb_ppu_common_pkg::*;
#(
    parameter int unsigned DMA_LEN     = OAM_DMA_LEN,
    parameter int unsigned START_DELAY = 1
) (
    input  logic        clk_m,
    input  logic        reset,
    input  logic        dma_start,
    input  logic [15:0] dma_start_addr,
    input  logic [7:0]  bus_rdata,
    output logic        bus_rd,
    output logic [15:0] bus_addr,
    output logic        oam_wr,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        dma_active,
    output logic        dma_done
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);
    localparam logic [3:0] DLY_LAST = 4'(START_DELAY - 1);

    dma_state_t  state_q, state_d;
    logic [7:0]  src_hi_q, src_hi_d;
    logic [7:0]  idx_q, idx_d;
    logic [3:0]  dly_q, dly_d;
    logic        bus_rd_q, bus_rd_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic        wr_pending_q;
    logic [7:0]  wr_idx_q;

    // Only the page number of the source address matters.
    logic unused_addr_lo;
    assign unused_addr_lo = ^dma_start_addr[7:0];

    // Next-state and registered-output decode; a start always restarts.
    always_comb begin
        state_d    = state_q;
        src_hi_d   = src_hi_q;
        idx_d      = idx_q;
        dly_d      = dly_q;
        done_d     = 1'b0;
        if (dma_start) begin
            state_d  = START;
            src_hi_d = dma_start_addr[15:8];
            idx_d    = 8'd0;
            dly_d    = 4'd0;
        end else begin
            unique case (state_q)
                IDLE: ;
                START: begin
                    if (dly_q == DLY_LAST) begin
                        state_d = XFER;
                        idx_d   = 8'd0;
                    end else begin
                        dly_d = dly_q + 4'd1;
                    end
                end
                XFER: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
                DRAIN: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        bus_rd_d   = (state_d == XFER);
        bus_addr_d = bus_rd_d ? {dma_src_eff(src_hi_d), idx_d}
                              : bus_addr_q;
        active_d   = (state_d != IDLE);
    end

    // Control state and registered bus/status outputs.
    always_ff @(posedge clk_m or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            src_hi_q   <= 8'h00;
            idx_q      <= 8'h00;
            dly_q      <= 4'h0;
            bus_rd_q   <= 1'b0;
            bus_addr_q <= 16'h0000;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_hi_q   <= src_hi_d;
            idx_q      <= idx_d;
            dly_q      <= dly_d;
            bus_rd_q   <= bus_rd_d;
            bus_addr_q <= bus_addr_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    // Write pipeline: every read becomes an OAM write one cycle later.
    always_ff @(posedge clk_m or negedge reset) begin
        if (!reset) begin
            wr_pending_q <= 1'b0;
            wr_idx_q     <= 8'h00;
        end else begin
            wr_pending_q <= bus_rd_q;
            wr_idx_q     <= bus_rd_q ? bus_addr_q[7:0] : wr_idx_q;
        end
    end

    assign bus_rd     = bus_rd_q;
    assign bus_addr   = bus_addr_q;
    assign oam_wr     = wr_pending_q;
    assign oam_addr   = wr_idx_q;
    assign oam_wdata  = bus_rdata;
    assign dma_active = active_q;
    assign dma_done   = done_q;

endmodule

// File: tb/tb_gb_oam_dma.sv
// Bench for gb_oam_dma: per-cycle schedule model plus
// hand-computed end-of-transfer expectations.
module tb_gb_oam_dma;

    localparam int N = 2048;

    logic        clk_m = 1'b0;
    logic        reset = 1'b0;
    logic        dma_start = 1'b0;
    logic [15:0] dma_start_addr = 16'h0000;
    logic [7:0]  bus_rdata = 8'h00;
    logic        bus_rd;
    logic [15:0] bus_addr;
    logic        oam_wr;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        dma_active;
    logic        dma_done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    bit          e_rd[N];
    logic [15:0] e_addr[N];
    bit          e_wr[N];
    logic [7:0]  e_waddr[N];
    logic [7:0]  e_wdata[N];
    bit          e_act[N];
    bit          e_done[N];

    int          act_cnt = 0;
    int          done_cnt = 0;
    int          wr_cnt = 0;
    logic [15:0] first_rd = 16'h0;
    logic [15:0] last_rd = 16'h0;
    bit          got_first = 0;
    logic [7:0]  oam_cap[160];

    gb_oam_dma dut (
        .clk_m          (clk_m),
        .reset          (reset),
        .dma_start      (dma_start),
        .dma_start_addr (dma_start_addr),
        .bus_rdata      (bus_rdata),
        .bus_rd         (bus_rd),
        .bus_addr       (bus_addr),
        .oam_wr         (oam_wr),
        .oam_addr       (oam_addr),
        .oam_wdata      (oam_wdata),
        .dma_active     (dma_active),
        .dma_done       (dma_done)
    );

    always #5 clk_m = ~clk_m;

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC1);
    endfunction

    always @(posedge clk_m) cyc <= cyc + 1;

    always @(posedge clk_m) if (bus_rd) bus_rdata <= mem(bus_addr);

    always @(posedge clk_m)
        if (oam_wr && oam_addr < 8'd160) oam_cap[oam_addr] <= oam_wdata;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Transfer whose start is sampled at edge e0 (cycle e0 follows it).
    function automatic void launch(input int e0, input logic [15:0] sa);
        logic [7:0]  hi;
        logic [7:0]  eff;
        logic [15:0] a;
        hi  = sa[15:8];
        eff = (hi >= 8'hE0) ? hi - 8'h20 : hi;
        for (int c = e0; c < N; c++) begin
            e_rd[c]   = 0;
            e_act[c]  = 0;
            e_done[c] = 0;
            if (c > e0) e_wr[c] = 0;
        end
        for (int k = 0; k < 162; k++) e_act[e0 + k] = 1;
        for (int i = 0; i < 160; i++) begin
            a = {eff, 8'(i)};
            e_rd[e0 + 1 + i]    = 1;
            e_addr[e0 + 1 + i]  = a;
            e_wr[e0 + 2 + i]    = 1;
            e_waddr[e0 + 2 + i] = 8'(i);
            e_wdata[e0 + 2 + i] = mem(a);
        end
        e_done[e0 + 162] = 1;
    endfunction

    function automatic void clear_model(input int c0);
        for (int c = c0; c < N; c++) begin
            e_rd[c]   = 0;
            e_wr[c]   = 0;
            e_act[c]  = 0;
            e_done[c] = 0;
        end
    endfunction

    initial begin
        forever begin
            @(negedge clk_m);
            if (cyc < N) begin
                chk("bus_rd", bus_rd, e_rd[cyc]);
                if (e_rd[cyc]) chk("bus_addr", bus_addr, e_addr[cyc]);
                chk("oam_wr", oam_wr, e_wr[cyc]);
                if (e_wr[cyc]) begin
                    chk("oam_addr", oam_addr, e_waddr[cyc]);
                    chk("oam_wdata", oam_wdata, e_wdata[cyc]);
                end
                chk("dma_active", dma_active, e_act[cyc]);
                chk("dma_done", dma_done, e_done[cyc]);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_m);
            #1;
            if (dma_active) act_cnt++;
            if (dma_done) done_cnt++;
            if (oam_wr) wr_cnt++;
            if (bus_rd) begin
                if (!got_first) first_rd = bus_addr;
                got_first = 1;
                last_rd = bus_addr;
            end
        end
    end

    task automatic clr();
        act_cnt   = 0;
        done_cnt  = 0;
        wr_cnt    = 0;
        got_first = 0;
        first_rd  = 16'h0;
        last_rd   = 16'h0;
    endtask

    task automatic start_dma(input logic [15:0] a);
        dma_start      = 1'b1;
        dma_start_addr = a;
        launch(cyc + 1, a);
        @(negedge clk_m);
        dma_start = 1'b0;
    endtask

    task automatic oam_all(input string nm, input logic [7:0] x);
        int bad;
        bad = 0;
        for (int i = 0; i < 160; i++)
            if (oam_cap[i] !== (8'(i) ^ x)) bad++;
        chk(nm, bad, 0);
    endtask

    task automatic find_rd(input logic [15:0] a, output bit ok);
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            if (bus_rd && bus_addr == a) begin
                ok = 1;
                break;
            end
            @(negedge clk_m);
        end
    endtask

    initial begin
        bit ok;
        reset = 1'b0;
        repeat (2) @(negedge clk_m);
        chk("rst_bus_rd", bus_rd, 0);
        chk("rst_bus_addr", bus_addr, 16'h0000);
        chk("rst_oam_wr", oam_wr, 0);
        chk("rst_oam_addr", oam_addr, 8'h00);
        chk("rst_active", dma_active, 0);
        chk("rst_done", dma_done, 0);

        dma_start      = 1'b1;
        dma_start_addr = 16'hC100;
        @(negedge clk_m);
        dma_start = 1'b0;
        reset     = 1'b1;
        clr();
        repeat (5) @(negedge clk_m);
        chk("start_in_reset_act", act_cnt, 0);

        clr();
        start_dma(16'hC100);
        repeat (170) @(negedge clk_m);
        chk("t1_active_cycles", act_cnt, 162);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_wr_cnt", wr_cnt, 160);
        chk("t1_first_rd", first_rd, 16'hC100);
        chk("t1_last_rd", last_rd, 16'hC19F);
        chk("t1_oam0", oam_cap[0], 8'h5A);
        chk("t1_oam159", oam_cap[159], 8'hC5);
        oam_all("t1_oam_all", 8'h5A);

        clr();
        start_dma(16'hFE00);
        repeat (170) @(negedge clk_m);
        chk("t2_first_rd", first_rd, 16'hDE00);
        chk("t2_last_rd", last_rd, 16'hDE9F);
        chk("t2_done_cnt", done_cnt, 1);

        clr();
        start_dma(16'hDF37);
        repeat (170) @(negedge clk_m);
        chk("t3_first_rd", first_rd, 16'hDF00);
        chk("t3_last_rd", last_rd, 16'hDF9F);

        clr();
        start_dma(16'hC100);
        find_rd(16'hC150, ok);
        chk("t4_find_idx80", ok, 1);
        if (ok) start_dma(16'hD000);
        repeat (170) @(negedge clk_m);
        chk("t4_active_cycles", act_cnt, 244);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_last_rd", last_rd, 16'hD09F);
        chk("t4_oam0", oam_cap[0], 8'h55);
        chk("t4_oam159", oam_cap[159], 8'hCA);
        oam_all("t4_oam_all", 8'h55);

        clr();
        start_dma(16'hC100);
        find_rd(16'hC132, ok);
        chk("t5_find_idx50", ok, 1);
        @(posedge clk_m);
        #2;
        reset = 1'b0;
        clear_model(cyc);
        #1;
        chk("t5_bus_rd", bus_rd, 0);
        chk("t5_bus_addr", bus_addr, 16'h0000);
        chk("t5_oam_wr", oam_wr, 0);
        chk("t5_oam_addr", oam_addr, 8'h00);
        chk("t5_active", dma_active, 0);
        chk("t5_done", dma_done, 0);
        @(negedge clk_m);
        @(negedge clk_m);
        reset = 1'b1;
        clr();
        repeat (20) @(negedge clk_m);
        chk("t5_wr_after", wr_cnt, 0);
        chk("t5_act_after", act_cnt, 0);

        clr();
        start_dma(16'hC100);
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            if (!bus_rd && oam_wr && oam_addr == 8'd159) begin
                ok = 1;
                break;
            end
            @(negedge clk_m);
        end
        chk("t6_find_drain", ok, 1);
        if (ok) start_dma(16'hE000);
        repeat (170) @(negedge clk_m);
        chk("t6_active_cycles", act_cnt, 324);
        chk("t6_done_cnt", done_cnt, 1);
        chk("t6_first_rd", first_rd, 16'hC100);
        chk("t6_last_rd", last_rd, 16'hC09F);
        chk("t6_oam0", oam_cap[0], 8'hA5);
        chk("t6_oam159", oam_cap[159], 8'h3A);
        oam_all("t6_oam_all", 8'hA5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gb_oam_dma.md
# gb_oam_dma

OAM DMA controller for the GameBoy PPU. It turns the PPU register file's `dma_start` pulse and `dma_start_addr` source page into a sequenced 160-byte copy from the system bus into OAM (0xFE00-0xFE9F), one byte per M-cycle. While the copy runs it drives `dma_active`, which the top level uses to block CPU bus access (except HRAM) and PPU OAM reads. It sits between the PPU control registers, the system bus read port and the OAM write port.

## Interface
- `DMA_LEN`, 160: bytes per transfer (OAM size).
- `START_DELAY`, 1: idle M-cycles between the start pulse and the first source read.
- `clk_m`  in  1  machine clock (~1MHz); the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `dma_start`  in  1  single-cycle request pulse from the 0xFF46 write.
- `dma_start_addr`  in  16  source base; only [15:8] is used, [7:0] is ignored.
- `bus_rdata`  in  8  source data, valid the cycle after `bus_rd`.
- `bus_rd`  out  1  source read strobe.
- `bus_addr`  out  16  source read address.
- `oam_wr`  out  1  OAM write strobe.
- `oam_addr`  out  8  OAM byte index, 0..159.
- `oam_wdata`  out  8  OAM write data; combinational pass-through of `bus_rdata`.
- `dma_active`  out  1  high from the cycle after the start pulse through the cycle of the last OAM write.
- `dma_done`  out  1  one-cycle pulse in the cycle after the last OAM write.

## Operation
- States: IDLE, START, XFER, DRAIN.
- IDLE + `dma_start`: latch `src_hi = dma_start_addr[15:8]`, clear the start-delay counter, go to START.
- START: hold for `START_DELAY` cycles. `bus_rd` = 0. Then go to XFER with `idx` = 0.
- XFER: `bus_rd` = 1 and `bus_addr = {src_eff, idx}`.
  - `idx` increments each cycle.
  - After the read with `idx` = `DMA_LEN`-1, go to DRAIN.
- DRAIN: one cycle for the final write, then IDLE.
- Source remap: if `src_hi` >= 0xE0, `src_eff = src_hi - 0x20`, so the 0xE0-0xFF pages map to echo RAM 0xC0-0xDF. Otherwise `src_eff = src_hi`.
- Write pipeline: each read sets `wr_pending` = 1 and `wr_idx` = `idx` for the next cycle. That cycle drives `oam_wr` = 1, `oam_addr` = `wr_idx`, `oam_wdata` = `bus_rdata`. The pipeline runs independently of the state.
- Restart: `dma_start` in any non-IDLE state takes effect at the next edge.
  - It latches the new `src_hi`, goes to START and resets `idx`.
  - An in-flight write still completes in that first START cycle.
  - `dma_active` stays high throughout; no `dma_done` is issued for the aborted transfer.
- `dma_start` pulses while `reset` is asserted are ignored.
- `idx` is 8 bits and never exceeds `DMA_LEN`-1. Addresses never wrap past the 256-byte page.

## Timing
- Reset values: state IDLE; `bus_rd`, `oam_wr`, `dma_active`, `dma_done` = 0; `bus_addr` = 0x0000; `oam_addr` = 0x00; `wr_pending` = 0; `src_hi` = 0x00.
- `dma_start` sampled at edge E0. With `START_DELAY` = 1:
  - E0..E1: START, `dma_active` = 1.
  - E1: first read, `idx` 0.
  - E2: first OAM write (addr 0) alongside the read for `idx` 1.
  - E160: last read (`idx` 159).
  - E161: DRAIN, write to addr 159.
  - E162: IDLE, `dma_done` = 1, `dma_active` = 0.
- `dma_active` lasts `START_DELAY` + `DMA_LEN` + 1 cycles (162 at defaults). It is registered, not combinational.
- Asynchronous reset mid-transfer: all outputs drop immediately to reset values. No partial write completes after reset assertion.
- All outputs except `oam_wdata` are registered.

## Structure
- `gb_ppu_common_pkg` gains:
  - `dma_state_t` (2-bit enum IDLE/START/XFER/DRAIN);
  - `OAM_DMA_LEN` = 160;
  - `OAM_BASE_ADDR` = 16'hFE00;
  - `ECHO_REMAP_THRESH` = 8'hE0.
- Single module; no sub-module is warranted. The write pipeline is two flops inside it.

## Test plan
- Start with `dma_start_addr` = 0xC100 and a memory model returning `addr[7:0]^0x5A` -> 160 writes: OAM[i] = i^0x5A, addresses 0xC100..0xC19F; `dma_active` high exactly 162 cycles; one `dma_done`.
- Start with source 0xFE00 -> reads issued at 0xDE00..0xDE9F (echo remap); 0xDF00 start -> 0xDF00..0xDF9F.
- Restart at `idx` 80 with new source 0xD000 -> write for `idx` 79 completes; next read 0xD000; OAM ends with the full 0xD0xx contents; `dma_active` never drops; a single `dma_done`.
- Assert `reset` low at `idx` 50 -> all outputs 0 in the same cycle; after release, IDLE and no writes until a new start.
- `dma_start` held/pulsed in the same cycle as DRAIN -> final write to addr 159 occurs, then a new transfer starts with no IDLE cycle; `dma_done` not pulsed.
- `dma_start_addr` low byte 0x37 -> ignored; the first read is still at {hi, 0x00}.
